// File: rtl/child_sched_pkg.sv
// Shared types and the round-robin pick helper for child schedulers under a hierarchy node.
package child_sched_pkg;

  localparam int unsigned DEFAULT_N_REQ = 5;
  localparam int unsigned PICK_MAX_N    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                  found;
    logic [3:0]            idx;
    logic [PICK_MAX_N-1:0] onehot;
  } rr_pick_t;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  function automatic rr_pick_t rr_pick(input logic [PICK_MAX_N-1:0] req,
                                       input logic [3:0]            ptr,
                                       input int unsigned           n);
    logic [PICK_MAX_N-1:0] rot;
    int unsigned           j;
    int unsigned           k;
    rr_pick_t              res;
    rot = '0;
    res = '0;
    k   = 0;
    for (int unsigned i = 0; i < PICK_MAX_N; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n) rot[i[3:0]] = req[j[3:0]];
    end
    for (int unsigned i = 0; i < PICK_MAX_N; i++) begin
      if (rot[i[3:0]] && !res.found) begin
        res.found = 1'b1;
        k         = i;
      end
    end
    j = 32'(ptr) + k;
    if (j >= n) j = j - n;
    res.idx               = j[3:0];
    res.onehot[j[3:0]]    = res.found;
    return res;
  endfunction

endpackage

// File: rtl/child_rr_sched_if.sv
// Request/grant bundle between the child instances, the shared resource and the scheduler.
interface child_rr_sched_if
  import child_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = DEFAULT_N_REQ,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_last;
  logic             res_ready;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic             beat_fire;
  logic [CNT_W-1:0] burst_cnt;
  logic             preempt;
  logic             abandon;

  modport master (
    input  req, req_last, res_ready,
    output gnt, gnt_valid, gnt_id, beat_fire, burst_cnt, preempt, abandon
  );

  modport slave (
    output req, req_last, res_ready,
    input  gnt, gnt_valid, gnt_id, beat_fire, burst_cnt, preempt, abandon
  );

endinterface

// File: rtl/child_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module child_rr_pick
  import child_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_found
);

  rr_pick_t w_pick;
  logic     w_unused_pick;

  assign w_pick  = rr_pick(PICK_MAX_N'(i_req), 4'(i_ptr), N_REQ);
  assign o_gnt   = w_pick.onehot[N_REQ-1:0];
  assign o_id    = w_pick.idx[ID_W-1:0];
  assign o_found = w_pick.found;

  // Upper bits of the fixed-width helper result are structurally zero for small N_REQ.
  assign w_unused_pick = &{1'b0, w_pick.onehot, w_pick.idx};

endmodule

// File: rtl/child_rr_sched.sv
// Round-robin burst scheduler sharing one resource port among N_REQ children.
module child_rr_sched
  import child_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = DEFAULT_N_REQ,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input logic              clk,
  input logic              rst_n,
  child_rr_sched_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  TOP_ID    = ID_W'(N_REQ - 1);

  sched_state_e     r_state,     w_state_nxt;
  logic [N_REQ-1:0] r_gnt,       w_gnt_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic [ID_W-1:0]  r_gnt_id,    w_gnt_id_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic             r_preempt,   w_preempt_nxt;
  logic             r_abandon,   w_abandon_nxt;
  logic [ID_W-1:0]  r_rr_ptr,    w_rr_ptr_nxt;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [ID_W-1:0]  w_pick_id;
  logic             w_pick_found;
  logic             w_own_req;
  logic             w_own_last;
  logic             w_beat_fire;

  child_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_id    (w_pick_id),
    .o_found (w_pick_found)
  );

  // Masking with the one-hot grant keeps non-owner request bits (even X) out of beat_fire.
  assign w_own_req   = |(bus.req & r_gnt);
  assign w_own_last  = |(bus.req_last & r_gnt);
  assign w_beat_fire = r_gnt_valid & w_own_req & bus.res_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_id_nxt    = r_gnt_id;
    w_burst_cnt_nxt = r_burst_cnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_preempt_nxt   = 1'b0;
    w_abandon_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = OWN;
          w_gnt_nxt       = w_pick_gnt;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_id_nxt    = w_pick_id;
          w_burst_cnt_nxt = '0;
        end
      end
      OWN: begin
        if (!w_own_req || (w_beat_fire && (w_own_last || (r_burst_cnt == LAST_BEAT)))) begin
          w_state_nxt     = IDLE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_burst_cnt_nxt = '0;
          w_rr_ptr_nxt    = (r_gnt_id == TOP_ID) ? '0 : r_gnt_id + ID_W'(1);
          w_abandon_nxt   = !w_own_req;
          // A last beat landing on the cap is a normal end, not a preemption.
          w_preempt_nxt   = w_beat_fire && !w_own_last;
        end else if (w_beat_fire) begin
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_burst_cnt <= '0;
      r_preempt   <= 1'b0;
      r_abandon   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_preempt   <= w_preempt_nxt;
      r_abandon   <= w_abandon_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.beat_fire = w_beat_fire;
  assign bus.burst_cnt = r_burst_cnt;
  assign bus.preempt   = r_preempt;
  assign bus.abandon   = r_abandon;

endmodule

// File: tb/tb_child_rr_sched.sv
// Directed plus randomized bench for child_rr_sched against a cycle-level reference model.
module tb_child_rr_sched;

  localparam int N  = 5;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  child_rr_sched_if #(.N_REQ(N), .MAX_BURST(MB)) bus ();

  child_rr_sched #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_err    = 0;
  int fire_cnt = 0;

  // Model: owner (-1 = none), fairness pointer, beats taken, last granted id, pending pulses.
  int m_owner, m_ptr, m_cnt, m_last_id;
  bit m_pre, m_ab;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_last_id = 0; m_pre = 0; m_ab = 0;
  endtask

  task automatic end_grant();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rq;
    logic [N-1:0] lst;
    int c;
    rq = bus.req; lst = bus.req_last;
    m_pre = 0; m_ab = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (bit_at(rq, c)) begin
          m_owner = c; m_last_id = c; m_cnt = 0;
          break;
        end
      end
    end else if (!bit_at(rq, m_owner)) begin
      m_ab = 1;
      end_grant();
    end else if (bus.res_ready) begin
      m_cnt++;
      if (bit_at(lst, m_owner)) end_grant();
      else if (m_cnt == MB) begin
        m_pre = 1;
        end_grant();
      end
    end
  endtask

  // Entered at posedge+1 with inputs already driven; checks mid-cycle, then advances one clock.
  task automatic cycle();
    logic [N-1:0] exp_gnt;
    bit exp_fire;
    #3;
    exp_gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    exp_fire = (m_owner >= 0) && bit_at(bus.req, m_owner) && bus.res_ready;
    check("gnt",       32'(bus.gnt),       32'(exp_gnt));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    check("gnt_id",    32'(bus.gnt_id),    32'(m_last_id));
    check("burst_cnt", 32'(bus.burst_cnt), 32'(m_cnt));
    check("beat_fire", 32'(bus.beat_fire), 32'(exp_fire));
    check("preempt",   32'(bus.preempt),   32'(m_pre));
    check("abandon",   32'(bus.abandon),   32'(m_ab));
    if (exp_fire) fire_cnt++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt),       32'd0);
    check({tag, "_valid"}, 32'(bus.gnt_valid), 32'd0);
    check({tag, "_id"},    32'(bus.gnt_id),    32'd0);
    check({tag, "_cnt"},   32'(bus.burst_cnt), 32'd0);
    check({tag, "_pre"},   32'(bus.preempt),   32'd0);
    check({tag, "_ab"},    32'(bus.abandon),   32'd0);
  endtask

  initial begin
    logic [N-1:0] flip;
    bit rdy_seq [4];
    int cnt_seq [4];
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    cnt_seq = '{1, 1, 1, 2};

    bus.req = '0; bus.req_last = '0; bus.res_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two requesters: child 2 first, then child 4 after one bubble.
    bus.req = 5'b10100; bus.res_ready = 1'b1;
    cycle();
    check("p1_gnt", 32'(bus.gnt), 32'b00100);
    check("p1_id",  32'(bus.gnt_id), 32'd2);
    cycle(); cycle();
    bus.req_last = 5'b00100;
    cycle();
    check("p1_end_valid", 32'(bus.gnt_valid), 32'd0);
    bus.req_last = '0;
    cycle();
    check("p1_next_gnt", 32'(bus.gnt), 32'b10000);
    bus.req = '0;
    cycle();
    check("p1_abandon", 32'(bus.abandon), 32'd1);
    cycle();

    // All requesting, single-beat bursts: strict rotation with a bubble between grants.
    bus.req = '1; bus.req_last = '1;
    for (int g = 0; g < 6; g++) begin
      cycle();
      check("rot_id", 32'(bus.gnt_id), 32'(g % N));
      cycle();
      check("rot_bubble", 32'(bus.gnt_valid), 32'd0);
    end
    bus.req = '0; bus.req_last = '0;
    cycle();

    // Child 1 alone hits the burst cap and is re-granted; then child 2 waiting wins.
    bus.req = 5'b00010;
    cycle();
    fire_cnt = 0;
    for (int b = 0; b < MB; b++) cycle();
    check("cap_fires",   32'(fire_cnt), 32'(MB));
    check("cap_preempt", 32'(bus.preempt), 32'd1);
    cycle();
    check("cap_regrant", 32'(bus.gnt_id), 32'd1);
    check("cap_pulse1",  32'(bus.preempt), 32'd0);
    bus.req = 5'b00110;
    for (int b = 0; b < MB; b++) cycle();
    check("cap2_preempt", 32'(bus.preempt), 32'd1);
    cycle();
    check("cap2_next", 32'(bus.gnt_id), 32'd2);
    bus.req = '0;
    cycle(); cycle();

    // Owner 3 drops its request after two beats.
    bus.req = 5'b01000;
    cycle(); cycle(); cycle();
    check("drop_cnt2", 32'(bus.burst_cnt), 32'd2);
    bus.req = '0;
    cycle();
    check("drop_abandon", 32'(bus.abandon), 32'd1);
    check("drop_cnt0",    32'(bus.burst_cnt), 32'd0);
    bus.req = '1; bus.req_last = '1;
    cycle();
    check("drop_ptr4", 32'(bus.gnt_id), 32'd4);
    cycle();
    bus.req = '0; bus.req_last = '0;
    cycle();

    // Ready stalls hold the count; a last beat exactly at the cap ends normally.
    bus.req = 5'b00001;
    cycle();
    for (int s = 0; s < 4; s++) begin
      bus.res_ready = rdy_seq[s];
      cycle();
      check("stall_cnt", 32'(bus.burst_cnt), 32'(cnt_seq[s]));
    end
    bus.res_ready = 1'b1;
    for (int b = 0; b < 5; b++) cycle();
    check("cap_cnt7", 32'(bus.burst_cnt), 32'(MB - 1));
    bus.req_last = 5'b00001;
    cycle();
    check("last_at_cap_pre",   32'(bus.preempt), 32'd0);
    check("last_at_cap_valid", 32'(bus.gnt_valid), 32'd0);
    bus.req = '0; bus.req_last = '0;
    cycle();

    // Asynchronous reset in the middle of a burst.
    bus.req = 5'b00100;
    cycle();
    for (int b = 0; b < 5; b++) cycle();
    check("pre_rst_cnt", 32'(bus.burst_cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    check("mid_rst_fire", 32'(bus.beat_fire), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req = '1;
    cycle();
    check("post_rst_gnt", 32'(bus.gnt), 32'b00001);

    // Randomized traffic with sticky requests.
    for (int t = 0; t < 800; t++) begin
      flip = N'($urandom) & N'($urandom) & N'($urandom);
      bus.req       = bus.req ^ flip;
      bus.req_last  = N'($urandom) & N'($urandom) & N'($urandom);
      bus.res_ready = ($urandom_range(3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
